// File: rtl/apb_sched_pkg.sv
// Shared types and helpers for the APB round-robin scheduler.
package apb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    // Owner-index width; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr < NUM_REQ, so one conditional subtract is enough for the wrap
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[pos[IDX_W-1:0]]   = 1'b1;
                idx                   = pos[IDX_W-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/apb_rr_scheduler.sv
// Shares one APB master port among NUM_REQ requesters with round-robin
// arbitration and an ACCESS-phase watchdog.
//   state  | meaning
//   IDLE   | arbitrate; grant is combinational, payload latched on the edge
//   SETUP  | psel=1, penable=0, always one cycle
//   ACCESS | psel=1, penable=1, wait for pready or watchdog expiry
module apb_rr_scheduler
    import apb_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic                      pready_i,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pslverr_i
);

    localparam int  IDX_W  = idx_width(NUM_REQ);
    localparam int  CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit  WDT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [CNT_W-1:0]     cnt;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_i),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign gnt_o = (state == IDLE) ? pick_gnt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            done_o    <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            paddr_o   <= '0;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        paddr_o   <= req_addr_i[pick_idx*ADDR_W +: ADDR_W];
                        pwrite_o  <= req_write_i[pick_idx];
                        pwdata_o  <= req_wdata_i[pick_idx*DATA_W +: DATA_W];
                        owner     <= pick_idx;
                        ptr       <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        cnt       <= '0;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a watchdog expiry in the same cycle
                    if (pready_i) begin
                        state     <= IDLE;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        done_o    <= NUM_REQ'(1) << owner;
                        err_o     <= pslverr_i;
                        rdata_o   <= pwrite_o ? '0 : prdata_i;
                    end else if (WDT_EN && (cnt == CNT_LAST)) begin
                        state     <= IDLE;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        done_o    <= NUM_REQ'(1) << owner;
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Self-checking bench for apb_rr_scheduler: vector table plus scoreboard queues.
module tb_apb_rr_scheduler;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_i = '0;
    logic [NR-1:0]     req_write_i = '0;
    logic [NR*AW-1:0]  req_addr_i = '0;
    logic [NR*DW-1:0]  req_wdata_i = '0;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     done_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic              psel_o;
    logic              penable_o;
    logic [AW-1:0]     paddr_o;
    logic              pwrite_o;
    logic [DW-1:0]     pwdata_o;
    logic              pready_i = 1'b0;
    logic [DW-1:0]     prdata_i = '0;
    logic              pslverr_i = 1'b0;

    always #5 clk = ~clk;

    apb_rr_scheduler #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .paddr_o     (paddr_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .pslverr_i   (pslverr_i)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
        logic        wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    exp_t q_gnt[$];
    exp_t q_setup[$];
    exp_t q_done[$];

    task automatic push_exp(input exp_t e);
        q_gnt.push_back(e);
        q_setup.push_back(e);
        q_done.push_back(e);
    endtask

    // APB slave model: pready after slv_wait ACCESS cycles
    int            slv_wait = 0;
    logic          slv_err = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int            wcnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (psel_o && penable_o) begin
            pready_i  = (wcnt == slv_wait);
            pslverr_i = slv_err;
            prdata_i  = slv_rdata;
            wcnt++;
        end else begin
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            prdata_i  = '0;
            wcnt      = 0;
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: grants, SETUP payload, ACCESS stability and completions
    int            gnt_cnt = 0;
    int            gnt_cyc[$];
    int            acc_cnt = 0;
    logic [AW-1:0] last_addr = '0;

    initial begin : mon
        exp_t          e;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            if (gnt_o != '0) begin
                gnt_cnt++;
                gnt_cyc.push_back(cyc);
                if (q_gnt.size() == 0) begin
                    check("gnt_unexpected", 64'(gnt_o), 64'd0);
                end else begin
                    e  = q_gnt.pop_front();
                    oh = NR'(1) << e.idx;
                    check("gnt_onehot", 64'(gnt_o), 64'(oh));
                end
            end
            if (psel_o && !penable_o) begin
                if (q_setup.size() == 0) begin
                    check("setup_unexpected", 64'(psel_o), 64'd0);
                end else begin
                    e = q_setup.pop_front();
                    check("setup_paddr", 64'(paddr_o), 64'(e.addr));
                    check("setup_pwrite", 64'(pwrite_o), 64'(e.wr));
                    if (e.wr) check("setup_pwdata", 64'(pwdata_o), 64'(e.wdata));
                    last_addr = paddr_o;
                end
            end
            if (psel_o && penable_o) begin
                acc_cnt++;
                check("access_paddr_stable", 64'(paddr_o), 64'(last_addr));
            end
            if (done_o != '0) begin
                if (q_done.size() == 0) begin
                    check("done_unexpected", 64'(done_o), 64'd0);
                end else begin
                    e  = q_done.pop_front();
                    oh = NR'(1) << e.idx;
                    check("done_onehot", 64'(done_o), 64'(oh));
                    check("done_rdata", 64'(rdata_o), 64'(e.rdata));
                    check("done_err", 64'(err_o), 64'(e.err));
                end
            end
        end
    end

    typedef struct {
        logic [NR-1:0] req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wt;
        logic          serr;
        logic [DW-1:0] prdata;
        int            idx;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            lat;
    } vec_t;

    // One transfer: drive, wait for grant, release, wait for completion latency
    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   n;
        int   lat;
        slv_wait  = v.wt;
        slv_err   = v.serr;
        slv_rdata = v.prdata;
        e.idx   = v.idx;
        e.addr  = v.addr;
        e.wr    = v.wr;
        e.wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        push_exp(e);
        @(posedge clk);
        #1;
        req_i = v.req;
        for (int k = 0; k < NR; k++) begin
            req_addr_i[k*AW +: AW]  = (k == v.idx) ? v.addr  : (v.addr ^ (32'h100 << k));
            req_wdata_i[k*DW +: DW] = (k == v.idx) ? v.wdata : ~v.wdata;
            req_write_i[k]          = (k == v.idx) ? v.wr    : ~v.wr;
        end
        #1;
        n = 0;
        while (gnt_o == '0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_gnt_seen"}, 64'(|gnt_o), 64'd1);
        @(posedge clk);
        #1;
        req_i = '0;
        lat = 1;
        while (done_o == '0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(v.lat));
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        int   n;
        exp_t e;

        #300000;
        $display("FAIL global_time_limit: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   base;
        exp_t e;

        // req, wr, addr, wdata, wait, serr, prdata, idx, exp_rdata, exp_err, latency
        vecs[0] = '{4'b0100, 1'b0, 32'h0000_1000, 32'h0,         2,  1'b0, 32'hA5A5_0001, 2, 32'hA5A5_0001, 1'b0, 5};
        vecs[1] = '{4'b0011, 1'b1, 32'h0000_2000, 32'hCAFE_0000, 0,  1'b0, 32'h5555_5555, 0, 32'h0,         1'b0, 3};
        vecs[2] = '{4'b0011, 1'b1, 32'h0000_2004, 32'hCAFE_0001, 0,  1'b1, 32'h0000_7777, 1, 32'h0,         1'b1, 3};
        vecs[3] = '{4'b1111, 1'b0, 32'h0000_3000, 32'h0,         1,  1'b0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[4] = '{4'b1001, 1'b0, 32'h0000_4000, 32'h0,         0,  1'b1, 32'h0000_1234, 3, 32'h0000_1234, 1'b1, 3};
        vecs[5] = '{4'b1110, 1'b1, 32'h0000_5000, 32'h1357_9BDF, 3,  1'b0, 32'h1111_1111, 1, 32'h0,         1'b0, 6};
        vecs[6] = '{4'b0001, 1'b0, 32'h0000_6000, 32'h0,         15, 1'b0, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, 1'b0, 18};
        vecs[7] = '{4'b0010, 1'b0, 32'h0000_7000, 32'h0,         15, 1'b1, 32'h0000_0BAD, 1, 32'h0000_0BAD, 1'b1, 18};

        #3;
        check("rst_psel",    64'(psel_o),    64'd0);
        check("rst_penable", 64'(penable_o), 64'd0);
        check("rst_paddr",   64'(paddr_o),   64'd0);
        check("rst_pwdata",  64'(pwdata_o),  64'd0);
        check("rst_done",    64'(done_o),    64'd0);
        check("rst_rdata",   64'(rdata_o),   64'd0);
        check("rst_err",     64'(err_o),     64'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Watchdog: pready never comes, exactly TO ACCESS cycles then error
        acc_cnt = 0;
        hv = '{4'b0100, 1'b0, 32'h0000_8000, 32'h0, 1000, 1'b0, 32'h9999_9999, 2, 32'h0, 1'b1, TO + 2};
        run_vec(hv, "timeout");
        check("timeout_access_cycles", 64'(acc_cnt), 64'(TO));
        check("timeout_psel_after", 64'(psel_o), 64'd0);
        hv = '{4'b1000, 1'b1, 32'h0000_8100, 32'hFEED_0001, 0, 1'b0, 32'h0, 3, 32'h0, 1'b0, 3};
        run_vec(hv, "after_timeout");

        // Round-robin with all requesters held: order 0,1,2,3,0, 3 cycles apart
        slv_wait = 0;
        slv_err  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e.idx   = k % NR;
            e.addr  = 32'h0000_9000 + 32'(4 * (k % NR));
            e.wr    = 1'b1;
            e.wdata = 32'h10 + 32'(k % NR);
            e.rdata = '0;
            e.err   = 1'b0;
            push_exp(e);
        end
        base = gnt_cnt;
        gnt_cyc.delete();
        @(posedge clk);
        #1;
        req_i       = '1;
        req_write_i = '1;
        for (int k = 0; k < NR; k++) begin
            req_addr_i[k*AW +: AW]  = 32'h0000_9000 + 32'(4 * k);
            req_wdata_i[k*DW +: DW] = 32'h10 + 32'(k);
        end
        n = 0;
        while (gnt_cnt < base + 5 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        req_i = '0;
        check("rr_grant_count", 64'(gnt_cnt - base), 64'd5);
        n = 0;
        while (q_done.size() != 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rr_all_done", 64'(q_done.size()), 64'd0);
        for (int k = 1; k < gnt_cyc.size(); k++) begin
            check($sformatf("rr_spacing%0d", k), 64'(gnt_cyc[k] - gnt_cyc[k-1]), 64'd3);
        end

        // ptr=1 here; a read to requester 2 leaves ptr=3 and rdata nonzero
        hv = '{4'b0100, 1'b0, 32'h0000_A000, 32'h0, 0, 1'b0, 32'h600D_600D, 2, 32'h600D_600D, 1'b0, 3};
        run_vec(hv, "pre_reset_read");

        // Reset in the middle of ACCESS
        slv_wait  = 1000;
        slv_err   = 1'b0;
        e.idx   = 0;
        e.addr  = 32'h0000_B000;
        e.wr    = 1'b1;
        e.wdata = 32'h0BAD_F00D;
        e.rdata = '0;
        e.err   = 1'b0;
        push_exp(e);
        @(posedge clk);
        #1;
        req_i                 = 4'b0001;
        req_write_i           = 4'b0001;
        req_addr_i[0 +: AW]   = 32'h0000_B000;
        req_wdata_i[0 +: DW]  = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        req_i = '0;
        n = 0;
        while (!(psel_o && penable_o) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_reset_in_access", 64'(penable_o), 64'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_reset_psel",    64'(psel_o),    64'd0);
        check("mid_reset_penable", 64'(penable_o), 64'd0);
        check("mid_reset_done",    64'(done_o),    64'd0);
        check("mid_reset_paddr",   64'(paddr_o),   64'd0);
        check("mid_reset_pwrite",  64'(pwrite_o),  64'd0);
        check("mid_reset_rdata",   64'(rdata_o),   64'd0);
        check("mid_reset_err",     64'(err_o),     64'd0);
        void'(q_done.pop_back());
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // ptr restarts at 0: 1001 picks 0, then 1000 picks 3
        hv = '{4'b1001, 1'b0, 32'h0000_C000, 32'h0, 0, 1'b0, 32'h0000_C0C0, 0, 32'h0000_C0C0, 1'b0, 3};
        run_vec(hv, "post_reset_ptr");
        hv = '{4'b1000, 1'b1, 32'h0000_D000, 32'hD00D_0003, 0, 1'b0, 32'h0, 3, 32'h0, 1'b0, 3};
        run_vec(hv, "post_reset_req3");

        repeat (3) @(posedge clk);
        #1;
        check("final_done_queue", 64'(q_done.size()), 64'd0);
        check("final_gnt_queue", 64'(q_gnt.size()), 64'd0);
        check("final_idle_psel", 64'(psel_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
